// File: rtl/axum_ctx_rf_pkg.sv
// rtl/axum_ctx_rf_pkg.sv - shared types and constants for the multi-context register-file bank
package axum_ctx_rf_pkg;

    typedef enum logic {B_IDLE, B_RMW} bus_state_e;
    typedef enum logic {C_IDLE, C_RUN} copy_state_e;

    localparam logic [6:0] CTRL_CMD_OFF    = 7'h00;
    localparam logic [6:0] CTRL_STATUS_OFF = 7'h04;

    localparam int STS_BUSY   = 0;
    localparam int STS_DONE   = 1;
    localparam int STS_ABORT  = 2;
    localparam int STS_REJECT = 3;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_SRC_LSB   = 8;
    localparam int CMD_DST_LSB   = 16;

endpackage

// File: rtl/axum_reg_file_fpga.sv
// rtl/axum_reg_file_fpga.sv - one context's register file: three async read ports, one write port
module axum_reg_file_fpga #(
    parameter int NumRegs  = 32,
    parameter int RegWidth = 32
) (
    input  logic                i_clk,
    input  logic [4:0]          i_raddr_a,
    input  logic [4:0]          i_raddr_b,
    input  logic [4:0]          i_raddr_c,
    output logic [RegWidth-1:0] o_rdata_a,
    output logic [RegWidth-1:0] o_rdata_b,
    output logic [RegWidth-1:0] o_rdata_c,
    input  logic [4:0]          i_waddr,
    input  logic                i_we,
    input  logic [RegWidth-1:0] i_wdata
);

    localparam int IdxBits = $clog2(NumRegs);

    logic [RegWidth-1:0] r_mem [NumRegs];

    // x0 and anything beyond the implemented register count read as zero and ignore writes
    function automatic logic f_valid(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NumRegs);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_we && f_valid(i_waddr)) begin
            r_mem[i_waddr[IdxBits-1:0]] <= i_wdata;
        end
    end

    assign o_rdata_a = f_valid(i_raddr_a) ? r_mem[i_raddr_a[IdxBits-1:0]] : '0;
    assign o_rdata_b = f_valid(i_raddr_b) ? r_mem[i_raddr_b[IdxBits-1:0]] : '0;
    assign o_rdata_c = f_valid(i_raddr_c) ? r_mem[i_raddr_c[IdxBits-1:0]] : '0;

endmodule

// File: rtl/axum_ctx_rf_ctrl.sv
// rtl/axum_ctx_rf_ctrl.sv - context register-file bank with bus window to inactive contexts and copy engine
module axum_ctx_rf_ctrl #(
    parameter bit RV32E        = 1'b0,
    parameter int NumCtx       = 4,
    parameter int RegWidth     = 32,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rf_map_req_i,
    output logic                        rf_map_gnt_o,
    input  logic [AddressWidth-1:0]     rf_map_addr_i,
    input  logic                        rf_map_we_i,
    input  logic [DataWidth/8-1:0]      rf_map_be_i,
    input  logic [DataWidth-1:0]        rf_map_wdata_i,
    output logic                        rf_map_rvalid_o,
    output logic [DataWidth-1:0]        rf_map_rdata_o,
    output logic                        rf_map_err_o,
    output logic                        rf_map_intr_o,
    input  logic [4:0]                  rf_raddr_a_i,
    input  logic [4:0]                  rf_raddr_b_i,
    output logic [RegWidth-1:0]         rf_rdata_a_o,
    output logic [RegWidth-1:0]         rf_rdata_b_o,
    input  logic [4:0]                  rf_waddr_wb_i,
    input  logic                        rf_we_wb_i,
    input  logic [RegWidth-1:0]         rf_wdata_wb_i,
    input  logic [$clog2(NumCtx)-1:0]   rf_ctx_sel_i
);

    import axum_ctx_rf_pkg::*;

    localparam int         NumRegs = RV32E ? 16 : 32;
    localparam int         CtxBits = $clog2(NumCtx);
    localparam int         NumBe   = DataWidth / 8;
    localparam logic [4:0] LastReg = 5'(NumRegs - 1);

    logic [RegWidth-1:0]  w_rdata_a [NumCtx];
    logic [RegWidth-1:0]  w_rdata_b [NumCtx];
    logic [RegWidth-1:0]  w_rdata_c [NumCtx];
    logic [4:0]           w_raddr_c [NumCtx];
    logic [4:0]           w_waddr   [NumCtx];
    logic                 w_we      [NumCtx];
    logic [RegWidth-1:0]  w_wdata   [NumCtx];

    bus_state_e           r_bstate;
    copy_state_e          r_cstate;
    logic [CtxBits-1:0]   r_src, r_dst;
    logic [4:0]           r_cnt;
    logic                 r_done, r_abort, r_reject, r_intr;
    logic                 r_rvalid, r_err;
    logic [DataWidth-1:0] r_rdata, r_old;

    logic                 w_ctrl_win;
    logic [CtxBits-1:0]   w_tgt_ctx;
    logic [4:0]           w_tgt_reg;
    logic [6:0]           w_ctrl_off;
    logic                 w_unused_addr;

    assign w_ctrl_win    = rf_map_addr_i[CtxBits+7];
    assign w_tgt_ctx     = rf_map_addr_i[CtxBits+6:7];
    assign w_tgt_reg     = rf_map_addr_i[6:2];
    assign w_ctrl_off    = rf_map_addr_i[6:0];
    assign w_unused_addr = ^rf_map_addr_i[AddressWidth-1:CtxBits+8];

    logic                 w_copy_busy, w_blocked, w_rf_err, w_full_be;
    logic [DataWidth-1:0] w_bus_rd, w_merged, w_status;

    assign w_copy_busy = (r_cstate == C_RUN);
    assign w_blocked   = !w_ctrl_win && w_copy_busy && (w_tgt_ctx == r_src || w_tgt_ctx == r_dst);
    assign w_rf_err    = (w_tgt_ctx == rf_ctx_sel_i) || (RV32E && w_tgt_reg[4]);
    assign w_full_be   = &rf_map_be_i;
    assign w_bus_rd    = w_rdata_c[w_tgt_ctx];

    always_comb begin
        w_status             = '0;
        w_status[STS_BUSY]   = w_copy_busy;
        w_status[STS_DONE]   = r_done;
        w_status[STS_ABORT]  = r_abort;
        w_status[STS_REJECT] = r_reject;
    end

    always_comb begin
        w_merged = r_old;
        for (int i = 0; i < NumBe; i++) begin
            if (rf_map_be_i[i]) w_merged[8*i +: 8] = rf_map_wdata_i[8*i +: 8];
        end
    end

    logic                 w_gnt, w_bus_we, w_resp_err, w_to_rmw;
    logic [DataWidth-1:0] w_bus_wdata, w_resp_data;

    always_comb begin
        w_gnt       = 1'b0;
        w_bus_we    = 1'b0;
        w_bus_wdata = rf_map_wdata_i;
        w_resp_err  = 1'b0;
        w_resp_data = '0;
        w_to_rmw    = 1'b0;
        if (rf_map_req_i && !w_blocked && !rst_i) begin
            if (r_bstate == B_IDLE) begin
                if (w_ctrl_win) begin
                    w_gnt = 1'b1;
                    if (!rf_map_we_i && w_ctrl_off == CTRL_STATUS_OFF) w_resp_data = w_status;
                end else if (w_rf_err) begin
                    w_gnt      = 1'b1;
                    w_resp_err = 1'b1;
                end else if (!rf_map_we_i) begin
                    w_gnt       = 1'b1;
                    w_resp_data = w_bus_rd;
                end else if (w_full_be) begin
                    w_gnt    = 1'b1;
                    w_bus_we = 1'b1;
                end else begin
                    w_to_rmw = 1'b1;
                end
            end else begin
                // The core may have switched onto the target while the old word was being fetched
                w_gnt = 1'b1;
                if (w_tgt_ctx == rf_ctx_sel_i) begin
                    w_resp_err = 1'b1;
                end else begin
                    w_bus_we    = 1'b1;
                    w_bus_wdata = w_merged;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bstate <= B_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_old    <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_resp_data;
            r_err    <= w_resp_err;
            case (r_bstate)
                B_IDLE: begin
                    if (w_to_rmw) begin
                        r_old    <= w_bus_rd;
                        r_bstate <= B_RMW;
                    end
                end
                B_RMW: begin
                    if (w_gnt) r_bstate <= B_IDLE;
                end
                default: r_bstate <= B_IDLE;
            endcase
        end
    end

    logic               w_host_wr, w_cmd_start, w_cmd_ok, w_sts_wr;
    logic [CtxBits-1:0] w_cmd_src, w_cmd_dst;
    logic               w_abort_now, w_copy_we, w_copy_fin;
    logic               w_done_n, w_abort_n, w_reject_n;

    assign w_host_wr   = w_gnt && w_ctrl_win && rf_map_we_i;
    assign w_cmd_start = w_host_wr && (w_ctrl_off == CTRL_CMD_OFF) && rf_map_wdata_i[CMD_START_BIT];
    assign w_sts_wr    = w_host_wr && (w_ctrl_off == CTRL_STATUS_OFF);
    assign w_cmd_src   = rf_map_wdata_i[CMD_SRC_LSB +: CtxBits];
    assign w_cmd_dst   = rf_map_wdata_i[CMD_DST_LSB +: CtxBits];
    assign w_cmd_ok    = !w_copy_busy && (w_cmd_src != w_cmd_dst)
                         && (w_cmd_src != rf_ctx_sel_i) && (w_cmd_dst != rf_ctx_sel_i);
    assign w_abort_now = w_copy_busy && (rf_ctx_sel_i == r_src || rf_ctx_sel_i == r_dst);
    assign w_copy_we   = w_copy_busy && !w_abort_now;
    assign w_copy_fin  = w_copy_we && (r_cnt == LastReg);
    assign w_done_n    = (r_done && !(w_sts_wr && rf_map_wdata_i[STS_DONE])) || w_copy_fin;
    assign w_abort_n   = (r_abort && !(w_sts_wr && rf_map_wdata_i[STS_ABORT])) || w_abort_now;
    assign w_reject_n  = (r_reject && !(w_sts_wr && rf_map_wdata_i[STS_REJECT]))
                         || (w_cmd_start && !w_cmd_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cstate <= C_IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
            r_reject <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            r_done   <= w_done_n;
            r_abort  <= w_abort_n;
            r_reject <= w_reject_n;
            r_intr   <= w_done_n || w_abort_n;
            case (r_cstate)
                C_IDLE: begin
                    if (w_cmd_start && w_cmd_ok) begin
                        r_src    <= w_cmd_src;
                        r_dst    <= w_cmd_dst;
                        r_cnt    <= 5'd1;
                        r_cstate <= C_RUN;
                    end
                end
                C_RUN: begin
                    if (w_abort_now || w_copy_fin) r_cstate <= C_IDLE;
                    else                          r_cnt    <= r_cnt + 5'd1;
                end
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    // Port c belongs to the copy engine on the source context, to the bus everywhere else
    always_comb begin
        for (int c = 0; c < NumCtx; c++) begin
            w_raddr_c[c] = (w_copy_busy && CtxBits'(c) == r_src) ? r_cnt : w_tgt_reg;
        end
    end

    always_comb begin
        for (int c = 0; c < NumCtx; c++) begin
            w_we[c]    = 1'b0;
            w_waddr[c] = rf_waddr_wb_i;
            w_wdata[c] = rf_wdata_wb_i;
            if (CtxBits'(c) == rf_ctx_sel_i) begin
                w_we[c] = rf_we_wb_i;
            end else if (w_copy_we && CtxBits'(c) == r_dst) begin
                w_we[c]    = 1'b1;
                w_waddr[c] = r_cnt;
                w_wdata[c] = w_rdata_c[r_src];
            end else if (w_bus_we && CtxBits'(c) == w_tgt_ctx) begin
                w_we[c]    = 1'b1;
                w_waddr[c] = w_tgt_reg;
                w_wdata[c] = w_bus_wdata;
            end
        end
    end

    for (genvar g = 0; g < NumCtx; g++) begin : g_ctx
        axum_reg_file_fpga #(
            .NumRegs  (NumRegs),
            .RegWidth (RegWidth)
        ) u_rf (
            .i_clk     (clk_i),
            .i_raddr_a (rf_raddr_a_i),
            .i_raddr_b (rf_raddr_b_i),
            .i_raddr_c (w_raddr_c[g]),
            .o_rdata_a (w_rdata_a[g]),
            .o_rdata_b (w_rdata_b[g]),
            .o_rdata_c (w_rdata_c[g]),
            .i_waddr   (w_waddr[g]),
            .i_we      (w_we[g]),
            .i_wdata   (w_wdata[g])
        );
    end

    assign rf_rdata_a_o    = w_rdata_a[rf_ctx_sel_i];
    assign rf_rdata_b_o    = w_rdata_b[rf_ctx_sel_i];
    assign rf_map_gnt_o    = w_gnt;
    assign rf_map_rvalid_o = r_rvalid;
    assign rf_map_rdata_o  = r_rdata;
    assign rf_map_err_o    = r_err;
    assign rf_map_intr_o   = r_intr;

endmodule

// File: tb/tb_axum_ctx_rf_ctrl.sv
// tb/tb_axum_ctx_rf_ctrl.sv - directed self-checking bench for axum_ctx_rf_ctrl
module tb_axum_ctx_rf_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rf_map_req_i = 1'b0;
    logic        rf_map_gnt_o;
    logic [31:0] rf_map_addr_i = '0;
    logic        rf_map_we_i = 1'b0;
    logic [3:0]  rf_map_be_i = '0;
    logic [31:0] rf_map_wdata_i = '0;
    logic        rf_map_rvalid_o;
    logic [31:0] rf_map_rdata_o;
    logic        rf_map_err_o;
    logic        rf_map_intr_o;
    logic [4:0]  rf_raddr_a_i = '0;
    logic [4:0]  rf_raddr_b_i = '0;
    logic [31:0] rf_rdata_a_o;
    logic [31:0] rf_rdata_b_o;
    logic [4:0]  rf_waddr_wb_i = '0;
    logic        rf_we_wb_i = 1'b0;
    logic [31:0] rf_wdata_wb_i = '0;
    logic [1:0]  rf_ctx_sel_i = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] CMD_A = 32'h200;
    localparam logic [31:0] STS_A = 32'h204;

    always #5 clk_i = ~clk_i;

    axum_ctx_rf_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rf_map_req_i    (rf_map_req_i),
        .rf_map_gnt_o    (rf_map_gnt_o),
        .rf_map_addr_i   (rf_map_addr_i),
        .rf_map_we_i     (rf_map_we_i),
        .rf_map_be_i     (rf_map_be_i),
        .rf_map_wdata_i  (rf_map_wdata_i),
        .rf_map_rvalid_o (rf_map_rvalid_o),
        .rf_map_rdata_o  (rf_map_rdata_o),
        .rf_map_err_o    (rf_map_err_o),
        .rf_map_intr_o   (rf_map_intr_o),
        .rf_raddr_a_i    (rf_raddr_a_i),
        .rf_raddr_b_i    (rf_raddr_b_i),
        .rf_rdata_a_o    (rf_rdata_a_o),
        .rf_rdata_b_o    (rf_rdata_b_o),
        .rf_waddr_wb_i   (rf_waddr_wb_i),
        .rf_we_wb_i      (rf_we_wb_i),
        .rf_wdata_wb_i   (rf_wdata_wb_i),
        .rf_ctx_sel_i    (rf_ctx_sel_i)
    );

    function automatic logic [31:0] rf_addr(input int ctx, input int r);
        return 32'((ctx << 7) | (r << 2));
    endfunction

    // Starts at a falling edge, returns at the falling edge where the response is sampled
    task automatic bus_xfer(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er,
                            output int waits, output logic rv);
        rf_map_req_i   = 1'b1;
        rf_map_addr_i  = a;
        rf_map_we_i    = we;
        rf_map_be_i    = be;
        rf_map_wdata_i = wd;
        waits = 0;
        #1;
        while (!rf_map_gnt_o && waits < 100) begin
            @(negedge clk_i);
            #1;
            waits++;
        end
        if (!rf_map_gnt_o) begin
            rf_map_req_i = 1'b0;
            rd = '0;
            er = 1'b0;
            rv = 1'b0;
            @(negedge clk_i);
        end else begin
            @(negedge clk_i);
            rv = rf_map_rvalid_o;
            rd = rf_map_rdata_o;
            er = rf_map_err_o;
            rf_map_req_i = 1'b0;
            rf_map_we_i  = 1'b0;
        end
    endtask

    task automatic core_wb(input logic [4:0] r, input logic [31:0] d);
        rf_waddr_wb_i = r;
        rf_wdata_wb_i = d;
        rf_we_wb_i    = 1'b1;
        @(negedge clk_i);
        rf_we_wb_i    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, rv; int w;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_cmp++; if ({rf_map_gnt_o, rf_map_rvalid_o, rf_map_err_o, rf_map_intr_o} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {rf_map_gnt_o, rf_map_rvalid_o, rf_map_err_o, rf_map_intr_o}); end
        n_cmp++; if (rf_map_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rf_map_rdata_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rv !== 1'b1 || w != 0) begin n_fail++; $display("FAIL reset_status_gnt: rvalid %b waits %0d want 1/0", rv, w); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rd); end
    endtask

    task automatic test_rf_window();
        logic [31:0] rd; logic er, rv; int w;
        bus_xfer(rf_addr(2, 5), 1'b1, 4'hf, 32'hDEADBEEF, rd, er, w, rv);
        n_cmp++; if (w != 0 || rv !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL rf_write: waits %0d rvalid %b err %b want 0/1/0", w, rv, er); end
        bus_xfer(rf_addr(2, 5), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (w != 0 || rv !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL rf_read_hs: waits %0d rvalid %b err %b want 0/1/0", w, rv, er); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rf_readback: got %h want deadbeef", rd); end
        @(negedge clk_i);
        n_cmp++; if (rf_map_rvalid_o !== 1'b0 || rf_map_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rvalid_single: rvalid %b rdata %h want 0/0", rf_map_rvalid_o, rf_map_rdata_o); end
        bus_xfer(rf_addr(2, 0), 1'b1, 4'hf, 32'hFFFFFFFF, rd, er, w, rv);
        n_cmp++; if (er !== 1'b0 || rv !== 1'b1) begin n_fail++; $display("FAIL x0_write_err: err %b rvalid %b want 0/1", er, rv); end
        bus_xfer(rf_addr(2, 0), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h want 0", rd); end
    endtask

    task automatic test_active_ctx_err();
        logic [31:0] rd; logic er, rv; int w;
        core_wb(5'd5, 32'h00000055);
        bus_xfer(rf_addr(0, 5), 1'b1, 4'hf, 32'h00000BAD, rd, er, w, rv);
        n_cmp++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL active_write_err: rvalid %b err %b rdata %h want 1/1/0", rv, er, rd); end
        bus_xfer(rf_addr(0, 5), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL active_read_err: rvalid %b err %b rdata %h want 1/1/0", rv, er, rd); end
        rf_raddr_a_i = 5'd5;
        rf_raddr_b_i = 5'd0;
        #1;
        n_cmp++; if (rf_rdata_a_o !== 32'h00000055) begin n_fail++; $display("FAIL core_x5: got %h want 00000055", rf_rdata_a_o); end
        n_cmp++; if (rf_rdata_b_o !== 32'h0) begin n_fail++; $display("FAIL core_x0: got %h want 0", rf_rdata_b_o); end
        @(negedge clk_i);
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic er, rv; int w;
        bus_xfer(rf_addr(2, 6), 1'b1, 4'hf, 32'h11223344, rd, er, w, rv);
        bus_xfer(rf_addr(2, 6), 1'b1, 4'b0010, 32'h0000AA00, rd, er, w, rv);
        n_cmp++; if (w != 1 || rv !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL rmw_latency: waits %0d rvalid %b err %b want 1/1/0", w, rv, er); end
        bus_xfer(rf_addr(2, 6), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL rmw_readback: got %h want 1122aa44", rd); end
    endtask

    task automatic test_copy();
        logic [31:0] rd; logic er, rv; int w; int busy_cnt;
        for (int k = 1; k < 32; k++) bus_xfer(rf_addr(1, k), 1'b1, 4'hf, 32'hC0DE0000 | k, rd, er, w, rv);
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00030101, rd, er, w, rv);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
            if (!rd[0]) break;
            busy_cnt++;
        end
        n_cmp++; if (busy_cnt != 31) begin n_fail++; $display("FAIL copy_busy_cycles: got %0d want 31", busy_cnt); end
        n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL copy_done_status: got %h want 2", rd); end
        n_cmp++; if (rf_map_intr_o !== 1'b1) begin n_fail++; $display("FAIL copy_intr: got %b want 1", rf_map_intr_o); end
        for (int k = 1; k < 32; k++) begin
            bus_xfer(rf_addr(3, k), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
            n_cmp++; if (rd !== (32'hC0DE0000 | k)) begin n_fail++; $display("FAIL copy_data x%0d: got %h want %h", k, rd, 32'hC0DE0000 | k); end
        end
        bus_xfer(STS_A, 1'b1, 4'hf, 32'h2, rd, er, w, rv);
        n_cmp++; if (rf_map_intr_o !== 1'b0) begin n_fail++; $display("FAIL w1c_intr: got %b want 0", rf_map_intr_o); end
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h want 0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, rv; int w;
        bus_xfer(rf_addr(2, 31), 1'b1, 4'hf, 32'h77777777, rd, er, w, rv);
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00020101, rd, er, w, rv);
        fork
            bus_xfer(rf_addr(1, 7), 1'b0, 4'hf, 32'h0, rd, er, w, rv);
            begin
                repeat (5) @(negedge clk_i);
                rf_ctx_sel_i = 2'd2;
            end
        join
        n_cmp++; if (w != 6) begin n_fail++; $display("FAIL blocked_gnt: waits %0d want 6", w); end
        n_cmp++; if (rd !== 32'hC0DE0007 || er !== 1'b0) begin n_fail++; $display("FAIL blocked_read: rdata %h err %b want c0de0007/0", rd, er); end
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL abort_status: got %h want 4", rd); end
        n_cmp++; if (rf_map_intr_o !== 1'b1) begin n_fail++; $display("FAIL abort_intr: got %b want 1", rf_map_intr_o); end
        rf_raddr_a_i = 5'd1;
        rf_raddr_b_i = 5'd5;
        #1;
        n_cmp++; if (rf_rdata_a_o !== 32'hC0DE0001 || rf_rdata_b_o !== 32'hC0DE0005) begin n_fail++; $display("FAIL partial_copied: x1 %h x5 %h want c0de0001/c0de0005", rf_rdata_a_o, rf_rdata_b_o); end
        rf_raddr_a_i = 5'd6;
        rf_raddr_b_i = 5'd31;
        #1;
        n_cmp++; if (rf_rdata_a_o !== 32'h1122AA44 || rf_rdata_b_o !== 32'h77777777) begin n_fail++; $display("FAIL partial_untouched: x6 %h x31 %h want 1122aa44/77777777", rf_rdata_a_o, rf_rdata_b_o); end
        @(negedge clk_i);
        bus_xfer(STS_A, 1'b1, 4'hf, 32'h4, rd, er, w, rv);
        rf_ctx_sel_i = 2'd0;
        n_cmp++; if (rf_map_intr_o !== 1'b0) begin n_fail++; $display("FAIL abort_clear_intr: got %b want 0", rf_map_intr_o); end
    endtask

    task automatic test_reject_and_reset();
        logic [31:0] rd; logic er, rv; int w;
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00010101, rd, er, w, rv);
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h8) begin n_fail++; $display("FAIL reject_same: got %h want 8", rd); end
        n_cmp++; if (rf_map_intr_o !== 1'b0) begin n_fail++; $display("FAIL reject_no_intr: got %b want 0", rf_map_intr_o); end
        bus_xfer(STS_A, 1'b1, 4'hf, 32'h8, rd, er, w, rv);
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00010001, rd, er, w, rv);
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h8) begin n_fail++; $display("FAIL reject_active: got %h want 8", rd); end
        bus_xfer(STS_A, 1'b1, 4'hf, 32'h8, rd, er, w, rv);
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00030101, rd, er, w, rv);
        bus_xfer(CMD_A, 1'b1, 4'hf, 32'h00030201, rd, er, w, rv);
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h9) begin n_fail++; $display("FAIL reject_busy: got %h want 9", rd); end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if ({rf_map_gnt_o, rf_map_rvalid_o, rf_map_err_o, rf_map_intr_o} !== 4'b0 || rf_map_rdata_o !== 32'h0) begin n_fail++; $display("FAIL midcopy_reset: flags %b rdata %h want 0000/0", {rf_map_gnt_o, rf_map_rvalid_o, rf_map_err_o, rf_map_intr_o}, rf_map_rdata_o); end
        rst_i = 1'b0;
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_status: got %h want 0", rd); end
        repeat (35) @(negedge clk_i);
        bus_xfer(STS_A, 1'b0, 4'hf, 32'h0, rd, er, w, rv);
        n_cmp++; if (rd !== 32'h0 || rf_map_intr_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: status %h intr %b want 0/0", rd, rf_map_intr_o); end
    endtask

    initial begin
        test_reset();
        test_rf_window();
        test_active_ctx_err();
        test_partial_write();
        test_copy();
        test_abort();
        test_reject_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
